// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Write-side master for the register file. Merges single-cycle ALU
//            results and variable-latency load results (buffered in a small
//            in-order queue) onto the file's single registered write port, and
//            keeps a per-register busy scoreboard for RAW hazard detection.
// Ports    : clock/reset          - rising-edge clock, async active-low reset
//            alu_valid/rd/data    - ALU result, never stalled
//            mem_valid/ready/rd/data - load result handshake into the queue
//            issue_valid/issue_rd - marks a destination busy at issue
//            chk_rs1/chk_rs2      - hazard lookup indices -> rs1_busy/rs2_busy
//            wEn/write_sel/write_data - registered register-file write port
//            q_count              - load queue occupancy
// Options  : WB_BYPASS_EN - adds rs1_fwd/rs2_fwd; a source matching the
//            register being written this cycle reads as not busy and gets
//            the write data forwarded.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic [ADDR_W-1:0]        chk_rs1,
    input  logic [ADDR_W-1:0]        chk_rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     wEn,
    output logic [ADDR_W-1:0]        write_sel,
    output logic [DATA_W-1:0]        write_data,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef WB_BYPASS_EN
    ,
    output logic [DATA_W-1:0]        rs1_fwd,
    output logic [DATA_W-1:0]        rs2_fwd
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [ADDR_W-1:0] qrd_q   [DEPTH];
    logic [ADDR_W-1:0] qrd_d   [DEPTH];
    logic [DATA_W-1:0] qdata_q [DEPTH];
    logic [DATA_W-1:0] qdata_d [DEPTH];
    logic              wen_q,  wen_d;
    logic [ADDR_W-1:0] sel_q,  sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic alu_take;
    logic push;
    logic pop;

    // Writes to x0 are meaningless: such ALU results free the slot for the
    // queue, and such loads complete their handshake without being stored.
    assign alu_take  = alu_valid && (alu_rd != '0);
    // Ready depends on registered occupancy only; a same-cycle pop of a full
    // queue does not open a slot until the next cycle.
    assign mem_ready = (count_q != CNT_W'(DEPTH));
    assign push      = mem_valid && mem_ready && (mem_rd != '0);
    assign pop       = !alu_take && (count_q != '0);

    // ------------------------------------------------------------------
    // Load queue next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        qrd_d    = qrd_q;
        qdata_d  = qdata_q;

        if (push) begin
            qrd_d[wr_ptr_q]   = mem_rd;
            qdata_d[wr_ptr_q] = mem_data;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Write port selection: ALU first, then queue head, else hold index/data
    // ------------------------------------------------------------------
    always_comb begin
        wen_d  = 1'b0;
        sel_d  = sel_q;
        data_d = data_q;
        if (alu_take) begin
            wen_d  = 1'b1;
            sel_d  = alu_rd;
            data_d = alu_data;
        end else if (pop) begin
            wen_d  = 1'b1;
            sel_d  = qrd_q[rd_ptr_q];
            data_d = qdata_q[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: clear on the cycle a write is presented, set on issue.
    // The set is applied last so it wins a same-index race.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[sel_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qrd_q[i]   <= '0;
                qdata_q[i] <= '0;
            end
            wen_q    <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            qrd_q    <= qrd_d;
            qdata_q  <= qdata_d;
            wen_q    <= wen_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wEn        = wen_q;
    assign write_sel  = sel_q;
    assign write_data = data_q;
    assign q_count    = count_q;

`ifdef WB_BYPASS_EN
    logic hit1;
    logic hit2;

    // The register being written this cycle is not yet visible in the file
    // read, so the consumer takes the value from the write port instead.
    assign hit1     = wen_q && (sel_q == chk_rs1) && (chk_rs1 != '0);
    assign hit2     = wen_q && (sel_q == chk_rs2) && (chk_rs2 != '0);
    assign rs1_busy = busy_q[chk_rs1] && !hit1;
    assign rs2_busy = busy_q[chk_rs2] && !hit2;
    assign rs1_fwd  = hit1 ? data_q : '0;
    assign rs2_fwd  = hit2 ? data_q : '0;
`else
    assign rs1_busy = busy_q[chk_rs1];
    assign rs2_busy = busy_q[chk_rs2];
`endif

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side master for the 32x32 register file.
- Merges single-cycle ALU results and variable-latency load results into the file's single write port (wEn/write_sel/write_data), at one write per cycle.
- Holds a per-register busy scoreboard so the issue stage can detect RAW hazards on pending destinations.
- Sits between execute/memory and the register file.

Parameters:
- DEPTH, 4, load-result queue entries (power of 2, >=2)
- DATA_W, 32, result data width
- ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle; never stalled
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  queue can accept load result
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load result
- issue_valid  in  1  instruction issued this cycle with destination issue_rd
- issue_rd  in  ADDR_W  destination to mark busy
- chk_rs1  in  ADDR_W  source 1 hazard lookup index
- chk_rs2  in  ADDR_W  source 2 hazard lookup index
- rs1_busy  out  1  chk_rs1 has a pending write
- rs2_busy  out  1  chk_rs2 has a pending write
- wEn  out  1  register file write enable
- write_sel  out  ADDR_W  register file write index
- write_data  out  DATA_W  register file write data
- q_count  out  log2(DEPTH)+1  load queue occupancy

Behaviour:
- Reset (reset=0, async): wEn=0, write_sel=0, write_data=0, queue emptied (q_count=0), all busy bits 0, mem_ready=1 once queue is empty.
- Write port is registered. A selection made in cycle t appears on wEn/write_sel/write_data in cycle t+1 and is captured by the register file at the end of t+1.
- Selection priority per cycle:
  - (1) alu_valid with alu_rd!=0;
  - (2) else queue head if q_count>0 (head popped);
  - (3) else wEn=0, write_sel/write_data hold previous values.
- alu_valid with alu_rd==0: ignored entirely. No write; the slot may be used by the queue.
- Load handshake: transfer when mem_valid && mem_ready.
  - mem_ready = (q_count != DEPTH), derived from registered state only.
  - A pop in the same cycle does NOT raise mem_ready when the queue is full.
- Accepted load with mem_rd==0: handshake completes; nothing enqueued.
- Queue is in-order FIFO with circular read/write pointers that wrap at DEPTH.
- Simultaneous push and pop: q_count unchanged; pop returns the older head entry.
- Starvation: sustained alu_valid starves the queue. Loads back-pressure via mem_ready; no data is ever lost.
- Scoreboard, busy[2**ADDR_W-1:0]:
  - issue_valid && issue_rd!=0 sets busy[issue_rd] at the clock edge.
  - A write on the port (wEn=1) clears busy[write_sel] at the end of that cycle.
  - Set and clear of the same index at the same edge: set wins.
  - busy[0] is constant 0.
- rsN_busy = busy[chk_rsN], combinational.
- Scoreboard is not tied to queue contents. The issue stage is responsible for not issuing a WAW to a busy register.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd, rs2_fwd (DATA_W each).
  - When wEn=1 and write_sel==chk_rsN and chk_rsN!=0: rsN_busy=0 and rsN_fwd=write_data in that cycle, so the consumer uses the forwarded value instead of the stale register file read.
  - Otherwise rsN_fwd=0.
- Undefined:
  - No forward ports.
  - rsN_busy stays 1 through the wEn cycle and falls the following cycle.

Test Plan:
- Reset mid-traffic: queue holding 3 entries, busy[5]=1, reset pulsed low between clock edges -> immediately wEn=0, q_count=0, rs1_busy=0 for chk_rs1=5, mem_ready=1.
- ALU write: issue_rd=7 at t; alu_valid, alu_rd=7, alu_data=0xDEADBEEF at t+2 -> wEn=1, write_sel=7, write_data=0xDEADBEEF at t+3; rs1_busy(chk_rs1=7) 1 through t+3, 0 at t+4.
- Queue fill/back-pressure (DEPTH=4): alu_valid=1 (rd=1) held continuously while offering 5 loads rd=2..6 -> 4 accepted, mem_ready=0, q_count=4. Drop alu_valid -> writes to regs 2,3,4,5 in order, then rd=6 is accepted.
- Priority collision: q_count=1 (rd=9, 0x11) and alu_valid rd=10, 0x22 in the same cycle -> reg 10 written first, then reg 9 the next cycle.
- x0 filtering: alu_rd=0 with valid, and mem_rd=0 accepted -> wEn never asserts for index 0, q_count unchanged, busy[0]=0 even with issue_rd=0.
- Set/clear race: wEn=1, write_sel=12 while issue_valid, issue_rd=12 -> busy[12] remains 1. With WB_BYPASS_EN, chk_rs1=12 in the wEn cycle gives rs1_busy=0 and rs1_fwd=write_data.
